// File: rtl/ov7670_frame_capture.sv
// OV7670 parallel-bus framer: packs byte pairs into RGB565 pixels and writes them to the frame buffer.
// Latency: the second byte sampled at edge n gives fb_we high in the cycle after edge n+2.
// Backpressure: none. The camera cannot be stalled, so the BRAM port must accept one write per cycle.
module ov7670_frame_capture #(
   parameter int H_ACT       = 320,
   parameter int V_ACT       = 240,
   parameter int SKIP_FRAMES = 2,
   parameter int ADDR_W      = 17
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              cap_en,
   input  logic              cam_vsync,
   input  logic              cam_href,
   input  logic [7:0]        cam_d,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [15:0]       fb_data,
   output logic              fb_we,
   output logic              frame_done,
   output logic              busy
);

   localparam int PW = $clog2(H_ACT + 1);
   localparam int LW = $clog2(V_ACT + 1);
   localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

   localparam logic [PW-1:0]     H_LIM  = PW'(H_ACT);
   localparam logic [LW-1:0]     V_LIM  = LW'(V_ACT);
   localparam logic [SW-1:0]     S_LIM  = SW'(SKIP_FRAMES);
   localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACT);

   typedef enum logic [1:0] {IDLE, SYNC, BLANK, ACTIVE} state_t;

   state_t state, state_nxt;

   // registered camera pins and their delayed copies for edge detection
   logic       vs_r, hr_r, vs_d, hr_d;
   logic [7:0] d_r;
   logic       vs_rise, vs_fall, hr_fall;

   // byte assembly and position tracking
   logic              phase;
   logic [7:0]        hi_byte;
   logic [PW-1:0]     pix;
   logic [LW-1:0]     line;
   logic [ADDR_W-1:0] line_base;
   logic [SW-1:0]     skip_cnt;
   logic              skipping;

   // completed pixel waiting one cycle before it is presented to the BRAM
   logic              pend_we;
   logic [ADDR_W-1:0] pend_addr;
   logic [15:0]       pend_dat;

   // FSM strobes
   logic clr_frame;
   logic end_frame;

   assign vs_rise  = vs_r & ~vs_d;
   assign vs_fall  = ~vs_r & vs_d;
   assign hr_fall  = ~hr_r & hr_d;
   assign skipping = (skip_cnt < S_LIM);
   assign busy     = (state == BLANK) || (state == ACTIVE);

   // input synchronising stage plus one-cycle history for edge detects
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         vs_r <= 1'b0;
         hr_r <= 1'b0;
         d_r  <= 8'h00;
         vs_d <= 1'b0;
         hr_d <= 1'b0;
      end else begin
         vs_r <= cam_vsync;
         hr_r <= cam_href;
         d_r  <= cam_d;
         vs_d <= vs_r;
         hr_d <= hr_r;
      end
   end

   // state register
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic; SYNC waits for a full VSYNC so a frame is never joined midway
   always_comb begin
      state_nxt = state;
      clr_frame = 1'b0;
      end_frame = 1'b0;
      case (state)
         IDLE: begin
            if (cap_en) state_nxt = SYNC;
         end
         SYNC: begin
            if (!cap_en)      state_nxt = IDLE;
            else if (vs_rise) state_nxt = BLANK;
         end
         BLANK: begin
            if (vs_fall) begin
               state_nxt = ACTIVE;
               clr_frame = 1'b1;
            end
         end
         ACTIVE: begin
            // cap_en is only sampled here so a started frame always completes
            if (vs_rise) begin
               end_frame = 1'b1;
               state_nxt = cap_en ? BLANK : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // byte pairing, pixel/line counters and skip-frame bookkeeping
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         phase     <= 1'b0;
         hi_byte   <= 8'h00;
         pix       <= '0;
         line      <= '0;
         line_base <= '0;
         skip_cnt  <= '0;
         pend_we   <= 1'b0;
         pend_addr <= '0;
         pend_dat  <= 16'h0000;
      end else begin
         pend_we <= 1'b0;
         if (clr_frame) begin
            phase     <= 1'b0;
            pix       <= '0;
            line      <= '0;
            line_base <= '0;
         end else if (state == ACTIVE) begin
            if (hr_r) begin
               phase <= ~phase;
               if (!phase) begin
                  hi_byte <= d_r;
               end else begin
                  pend_dat  <= {hi_byte, d_r};
                  pend_addr <= line_base + ADDR_W'(pix);
                  // overflow pixels/lines and skipped frames are counted but not written
                  pend_we   <= (pix < H_LIM) && (line < V_LIM) && !skipping;
                  if (pix < H_LIM) pix <= pix + 1'b1;
               end
            end else begin
               // a lone trailing byte is dropped by resetting the phase
               phase <= 1'b0;
               // frame end takes precedence over a coincident line end
               if (hr_fall && !vs_rise && (pix != '0)) begin
                  pix <= '0;
                  if (line < V_LIM) begin
                     line      <= line + 1'b1;
                     line_base <= line_base + H_STEP;
                  end
               end
            end
         end
         if (end_frame && skipping) skip_cnt <= skip_cnt + 1'b1;
      end
   end

   // BRAM write port; address and data hold between strobes
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= 16'h0000;
         frame_done <= 1'b0;
      end else begin
         fb_we      <= pend_we;
         frame_done <= end_frame && !skipping;
         if (pend_we) begin
            fb_addr <= pend_addr;
            fb_data <= pend_dat;
         end
      end
   end

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// Testbench for ov7670_frame_capture: two instances (no skip / two skipped frames) share one camera.
// Expected writes are queued as bytes are driven and popped when fb_we is observed.
// Camera timing is free-running; the DUT has no backpressure to exercise.
module tb_ov7670_frame_capture;

   localparam int H = 4;
   localparam int V = 2;
   localparam int AW = 17;

   logic          pclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cap_en = 1'b0;
   logic          cam_vsync = 1'b0;
   logic          cam_href = 1'b0;
   logic [7:0]    cam_d = 8'h00;

   logic [AW-1:0] addr0, addr2;
   logic [15:0]   data0, data2;
   logic          we0, we2, fd0, fd2, busy0, busy2;

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   data;
      int            cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q2[$];
   exp_t e0, e2;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done0   = 0;
   int done2   = 0;
   int exp_done0 = 0;
   int exp_done2 = 0;
   int skips2  = 0;
   int m_line  = 0;

   always #5 pclk = ~pclk;
   always @(posedge pclk) cyc <= cyc + 1;

   ov7670_frame_capture #(.H_ACT(H), .V_ACT(V), .SKIP_FRAMES(0), .ADDR_W(AW)) dut0 (
      .pclk(pclk), .rst_n(rst_n), .cap_en(cap_en),
      .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
      .fb_addr(addr0), .fb_data(data0), .fb_we(we0),
      .frame_done(fd0), .busy(busy0)
   );

   ov7670_frame_capture #(.H_ACT(H), .V_ACT(V), .SKIP_FRAMES(2), .ADDR_W(AW)) dut2 (
      .pclk(pclk), .rst_n(rst_n), .cap_en(cap_en),
      .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d),
      .fb_addr(addr2), .fb_data(data2), .fb_we(we2),
      .frame_done(fd2), .busy(busy2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // write monitors, sampled on the falling edge
   always @(negedge pclk) begin
      if (rst_n && we0) begin
         if (q0.size() == 0) begin
            check("dut0_unexpected_we", 32'(we0), 32'd0);
         end else begin
            e0 = q0.pop_front();
            check("dut0_addr", 32'(addr0), 32'(e0.addr));
            check("dut0_data", 32'(data0), 32'(e0.data));
            check("dut0_latency", 32'(cyc), 32'(e0.cyc));
         end
      end
      if (rst_n && we2) begin
         if (q2.size() == 0) begin
            check("dut2_unexpected_we", 32'(we2), 32'd0);
         end else begin
            e2 = q2.pop_front();
            check("dut2_addr", 32'(addr2), 32'(e2.addr));
            check("dut2_data", 32'(data2), 32'(e2.data));
            check("dut2_latency", 32'(cyc), 32'(e2.cyc));
         end
      end
      if (fd0) done0++;
      if (fd2) done2++;
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge pclk);
   endtask

   // one HREF pulse; w0/w2 say whether each instance stores this frame
   task automatic send_line(input int nbytes, input logic [7:0] base, input bit w0, input bit w2);
      logic [7:0] b_prev, b_cur;
      exp_t e;
      for (int b = 0; b < nbytes; b++) begin
         @(negedge pclk);
         b_cur    = base + 8'(b);
         cam_href = 1'b1;
         cam_d    = b_cur;
         if (b % 2 == 1 && (b / 2) < H && m_line < V) begin
            e.addr = AW'(m_line * H + b / 2);
            e.data = {b_prev, b_cur};
            e.cyc  = cyc + 3;
            if (w0) q0.push_back(e);
            if (w2) q2.push_back(e);
         end
         b_prev = b_cur;
      end
      @(negedge pclk);
      cam_href = 1'b0;
      cam_d    = 8'h00;
      if (nbytes >= 2 && m_line < V) m_line++;
      idle(4);
   endtask

   task automatic vs_pulse();
      @(negedge pclk);
      cam_vsync = 1'b1;
      idle(8);
   endtask

   // VSYNC low, up to three lines, then the closing VSYNC rise that ends the frame
   task automatic send_frame(input int l0, input int l1, input int l2, input logic [7:0] fb,
                             input bit cap, input bit drop_en);
      bit w0, w2;
      w0 = cap;
      w2 = cap && (skips2 >= 2);
      m_line = 0;
      @(negedge pclk);
      cam_vsync = 1'b0;
      idle(4);
      if (l0 > 0) send_line(l0, fb, w0, w2);
      if (drop_en) cap_en = 1'b0;
      if (l1 > 0) send_line(l1, fb + 8'h10, w0, w2);
      if (l2 > 0) send_line(l2, fb + 8'h20, w0, w2);
      idle(3);
      if (w0) exp_done0++;
      if (w2) exp_done2++;
      if (cap && skips2 < 2) skips2++;
      vs_pulse();
   endtask

   initial begin
      // reset asserted while the camera is mid-frame
      cap_en = 1'b1;
      idle(2);
      send_line(6, 8'hA0, 1'b0, 1'b0);
      check("rst_addr0", 32'(addr0), 32'd0);
      check("rst_data0", 32'(data0), 32'd0);
      check("rst_we0", 32'(we0), 32'd0);
      check("rst_done0", 32'(fd0), 32'd0);
      check("rst_busy0", 32'(busy0), 32'd0);
      check("rst_addr2", 32'(addr2), 32'd0);
      check("rst_data2", 32'(data2), 32'd0);
      check("rst_we2", 32'(we2), 32'd0);
      check("rst_done2", 32'(fd2), 32'd0);
      check("rst_busy2", 32'(busy2), 32'd0);

      // release mid-frame: the rest of this frame must not be written
      @(negedge pclk);
      rst_n = 1'b1;
      m_line = 0;
      send_line(8, 8'hB0, 1'b0, 1'b0);
      send_line(8, 8'hC0, 1'b0, 1'b0);
      check("sync_busy0", 32'(busy0), 32'd0);
      vs_pulse();
      check("blank_busy0", 32'(busy0), 32'd1);
      check("blank_busy2", 32'(busy2), 32'd1);

      // frame A: 2 x 8 bytes; dut2 skips it
      send_frame(8, 8, 0, 8'h01, 1'b1, 1'b0);
      check("A_done0", 32'(done0), 32'(exp_done0));
      check("A_done2", 32'(done2), 32'(exp_done2));
      check("A_hold_addr0", 32'(addr0), 32'd7);
      check("A_hold_data0", 32'(data0), 32'h1718);

      // frame B: long line, odd short line, excess line; dut2 skips it
      send_frame(10, 5, 8, 8'h21, 1'b1, 1'b0);
      check("B_done0", 32'(done0), 32'(exp_done0));
      check("B_done2", 32'(done2), 32'(exp_done2));

      // frame C: first stored frame for dut2, three lines with V=2
      send_frame(8, 8, 8, 8'h51, 1'b1, 1'b0);
      check("C_done0", 32'(done0), 32'(exp_done0));
      check("C_done2", 32'(done2), 32'(exp_done2));
      check("C_busy2", 32'(busy2), 32'd1);

      // frame D: cap_en drops after the first line; the frame still completes
      send_frame(8, 8, 0, 8'h61, 1'b1, 1'b1);
      check("D_done0", 32'(done0), 32'(exp_done0));
      check("D_done2", 32'(done2), 32'(exp_done2));
      check("D_idle_busy0", 32'(busy0), 32'd0);
      check("D_idle_busy2", 32'(busy2), 32'd0);

      // frame E: capture disabled, nothing written
      send_frame(8, 8, 0, 8'h81, 1'b0, 1'b0);
      check("E_done0", 32'(done0), 32'(exp_done0));
      check("E_done2", 32'(done2), 32'(exp_done2));
      check("E_busy0", 32'(busy0), 32'd0);

      idle(10);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q2_drained", 32'(q2.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
